pipe_mdu_ctrl: RTL and testbench
================================

Name: pipe_mdu_ctrl

Overview:
- Sequences a shared iterative multiply/divide unit that sits beside the EX-stage ALU of the five-stage pipeline.
- Accepts mult/multu/div/divu from EX, runs them over WIDTH cycles, and owns the HI/LO registers.
- Raises a pipeline stall when a later EX instruction needs HI/LO or the unit while it is busy.
- Independent instructions keep flowing while an operation is in flight.

Parameters:
WIDTH, 32, operand/HI/LO width; iteration count equals WIDTH; counter is clog2(WIDTH) bits.

Ports:
clk  in  1  pipeline clock, all state updates on rising edge
clrn  in  1  asynchronous active-low reset
start  in  1  EX holds a valid mult/multu/div/divu
op  in  2  00 mult, 01 multu, 10 div, 11 divu
a  in  WIDTH  rs operand (forwarded value)
b  in  WIDTH  rt operand (forwarded value)
rd_hilo  in  1  EX holds mfhi or mflo
mthi  in  1  EX holds mthi (write a to HI)
mtlo  in  1  EX holds mtlo (write a to LO)
cancel  in  1  flush of EX/in-flight op (exception/redirect)
stall  out  1  freeze PC, IF/ID and ID/EX this cycle
busy  out  1  state != IDLE
hi  out  WIDTH  HI register (remainder / product high)
lo  out  WIDTH  LO register (quotient / product low)
done  out  1  one-cycle pulse after HI/LO updated by an op
div0  out  1  pulses with done when divisor was zero

Behaviour:
- Reset (clrn=0, async): state=IDLE, count=0, hi=lo=0, done=div0=0, internal accumulators=0.
- States: IDLE, RUN, FIX.
- IDLE, start=1, cancel=0 and stall=0:
  - Capture op.
  - Signed ops capture |a|, |b|; unsigned ops capture raw values.
  - Record result signs: product/quotient = a[W-1]^b[W-1]; remainder = a[W-1]. Signs are 0 for unsigned ops.
  - count=0, go to RUN.
- RUN: one iteration per cycle.
  - Multiply: shift-add, 2W-bit accumulator.
  - Divide: restoring, 1 quotient bit per cycle.
  - After W iterations (count==W-1 at the edge), go to FIX.
- FIX (1 cycle): apply two's-complement negation per recorded signs; write hi/lo at the edge; go to IDLE; done=1 the following cycle.
- Latency: start accepted at edge E0; hi/lo valid after edge E0+W+1; done high during the cycle after that edge.
- Multiply result: hi=product[2W-1:W], lo=product[W-1:0].
- Divide result: lo=quotient, hi=remainder.
- Divide by zero: takes normal latency; lo=all ones; hi=original a; div0 pulses with done.
- Overflow case -2^(W-1)/-1: lo=0x80000000, hi=0 (natural wrap, no trap).
- stall = busy & (start | rd_hilo | mthi | mtlo). Combinational; it also covers the FIX cycle, so readers see the new values the cycle after FIX.
- mthi/mtlo in IDLE: write a into hi/lo at the edge.
- Simultaneous start and mthi/mtlo: start wins, move ignored.
- cancel=1:
  - Any state goes to IDLE at the next edge.
  - hi/lo are unchanged and no done is generated.
  - A start presented in the same cycle is ignored.
  - cancel during FIX also suppresses the hi/lo write.
- Reset mid-operation: immediate return to the reset values above; the partial result is discarded.
- Only hi/lo, done and div0 are visible outputs; intermediate accumulators never drive hi/lo before FIX.

Test Plan:
- Reset then multu a=0xFFFFFFFF b=0xFFFFFFFF -> after 33 edges hi=0xFFFFFFFE, lo=0x00000001, done pulses once, busy low.
- mult a=-7 (0xFFFFFFF9) b=6, then mflo on the next cycle -> stall held 33 cycles, then lo=0xFFFFFFD6, hi=0xFFFFFFFF.
- div a=-17 b=5 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFE (-2); divu a=17 b=5 -> lo=3, hi=2.
- div a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0; divu a=0x1234 b=0 -> lo=0xFFFFFFFF, hi=0x1234, div0=1 with done.
- Start mult, assert cancel at RUN cycle 10 -> IDLE next edge, hi/lo keep prior values, no done; mthi a=0xA5A5A5A5 in IDLE -> hi=0xA5A5A5A5 next edge.
- Independent ALU ops during RUN -> stall=0. Second mult while busy -> stall until FIX passes, then accepted; clrn low mid-RUN -> hi=lo=0, busy=0 immediately.

Source files
------------

// File: rtl/pipe_mdu_ctrl.sv
// Sequencer for the shared iterative multiply/divide unit beside the EX-stage ALU.
// Runs shift-add multiply / restoring divide over WIDTH cycles and owns HI/LO.
module pipe_mdu_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             rd_hilo,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic             cancel,
  output logic             stall,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             done,
  output logic             div0
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             r_state, w_state_nxt;
  logic [CW-1:0]      r_cnt;
  logic               r_div, r_sgn_q, r_sgn_r, r_dz;
  logic [WIDTH-1:0]   r_opnd;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_hi, r_lo;
  logic               r_done, r_div0;

  logic               w_signed, w_accept, w_last;
  logic [WIDTH-1:0]   w_a_abs, w_b_abs;
  logic [WIDTH:0]     w_madd, w_rsh, w_diff;
  logic               w_qbit;
  logic [2*WIDTH-1:0] w_mul_nxt, w_div_nxt, w_prod;
  logic [WIDTH-1:0]   w_quo, w_rem, w_fix_hi, w_fix_lo;

  assign busy  = (r_state != IDLE);
  assign stall = busy & (start | rd_hilo | mthi | mtlo);
  assign hi    = r_hi;
  assign lo    = r_lo;
  assign done  = r_done;
  assign div0  = r_div0;

  assign w_signed = ~op[0];
  assign w_accept = (r_state == IDLE) & start & ~cancel & ~stall;
  assign w_last   = (r_cnt == CW'(WIDTH-1));
  assign w_a_abs  = (w_signed & a[WIDTH-1]) ? -a : a;
  assign w_b_abs  = (w_signed & b[WIDTH-1]) ? -b : b;

  // Multiply: acc = {partial, multiplier}; add multiplicand on LSB, shift right with carry.
  assign w_madd    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_opnd : '0)};
  assign w_mul_nxt = {w_madd, r_acc[WIDTH-1:1]};

  // Divide: acc = {remainder, dividend/quotient}; shift left, trial subtract, restore on borrow.
  assign w_rsh     = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_diff    = w_rsh - {1'b0, r_opnd};
  assign w_qbit    = ~w_diff[WIDTH];
  assign w_div_nxt = {(w_qbit ? w_diff[WIDTH-1:0] : w_rsh[WIDTH-1:0]), r_acc[WIDTH-2:0], w_qbit};

  // Sign fix-up; a zero divisor forces an all-ones quotient regardless of sign.
  assign w_prod   = r_sgn_q ? -r_acc : r_acc;
  assign w_quo    = r_dz ? '1 : (r_sgn_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0]);
  assign w_rem    = r_sgn_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
  assign w_fix_hi = r_div ? w_rem : w_prod[2*WIDTH-1:WIDTH];
  assign w_fix_lo = r_div ? w_quo : w_prod[WIDTH-1:0];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = RUN;
      RUN:     if (w_last) w_state_nxt = FIX;
      FIX:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (cancel) w_state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_div   <= 1'b0;
      r_sgn_q <= 1'b0;
      r_sgn_r <= 1'b0;
      r_dz    <= 1'b0;
      r_opnd  <= '0;
      r_acc   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_done  <= 1'b0;
      r_div0  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= 1'b0;
      r_div0  <= 1'b0;
      if (w_accept) begin
        r_div   <= op[1];
        r_sgn_q <= w_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
        r_sgn_r <= w_signed & op[1] & a[WIDTH-1];
        r_dz    <= op[1] & (b == '0);
        r_opnd  <= op[1] ? w_b_abs : w_a_abs;
        r_acc   <= {{WIDTH{1'b0}}, (op[1] ? w_a_abs : w_b_abs)};
        r_cnt   <= '0;
      end else if (!cancel) begin
        case (r_state)
          RUN: begin
            r_acc <= r_div ? w_div_nxt : w_mul_nxt;
            r_cnt <= r_cnt + 1'b1;
          end
          FIX: begin
            r_hi   <= w_fix_hi;
            r_lo   <= w_fix_lo;
            r_done <= 1'b1;
            r_div0 <= r_dz;
          end
          default: begin
            // A start in the same cycle wins over a move.
            if (!start && mthi) r_hi <= a;
            if (!start && mtlo) r_lo <= a;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_pipe_mdu_ctrl.sv
// Directed bench for pipe_mdu_ctrl: expected HI/LO/div0 queued at issue, popped on done.
`timescale 1ns/1ps
module tb_pipe_mdu_ctrl;
  localparam int W = 32;

  logic         clk = 1'b0, clrn = 1'b0, start = 1'b0;
  logic         rd_hilo = 1'b0, mthi = 1'b0, mtlo = 1'b0, cancel = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0, b = '0;
  logic         stall, busy, done, div0;
  logic [W-1:0] hi, lo;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  pipe_mdu_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .clrn(clrn), .start(start), .op(op), .a(a), .b(b),
    .rd_hilo(rd_hilo), .mthi(mthi), .mtlo(mtlo), .cancel(cancel),
    .stall(stall), .busy(busy), .hi(hi), .lo(lo), .done(done), .div0(div0)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] eh, input logic [W-1:0] el, input logic ed);
    exp_t e;
    e.hi = eh; e.lo = el; e.dz = ed;
    q.push_back(e);
  endtask

  // Issue from IDLE, check done lands exactly W+1 edges after acceptance.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] eh, input logic [W-1:0] el, input logic ed);
    push(eh, el, ed);
    op = o; a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (W) tick();
    chk("pre_done", done, 0);
    tick();
    chk("done_lat", done, 1);
    chk("busy_after", busy, 0);
    tick();
    chk("done_pulse", done, 0);
  endtask

  always @(negedge clk) begin
    if (clrn && done) begin
      if (q.size() == 0) begin
        n_chk++;
        $display("FAIL spurious_done: got done=1 want no done");
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("res_hi", hi, e.hi);
        chk("res_lo", lo, e.lo);
        chk("res_div0", div0, e.dz);
      end
    end
  end

  initial begin
    int k;
    #2;
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_stall", stall, 0);
    tick(); tick();
    clrn = 1'b1;
    tick();

    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);

    // mult -7*6 followed by mflo held in EX
    push(32'hFFFFFFFF, 32'hFFFFFFD6, 1'b0);
    op = 2'b00; a = 32'hFFFFFFF9; b = 32'd6; start = 1'b1;
    tick();
    start = 1'b0; rd_hilo = 1'b1;
    #1;
    k = 0;
    while (stall && k < 40) begin k++; tick(); end
    chk("mflo_stall_cycles", k, 33);
    chk("mflo_lo", lo, 32'hFFFFFFD6);
    chk("mflo_hi", hi, 32'hFFFFFFFF);
    rd_hilo = 1'b0;
    tick(); tick();

    run_op(2'b10, 32'hFFFFFFEF, 32'd5, 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0);
    run_op(2'b11, 32'd17, 32'd5, 32'd2, 32'd3, 1'b0);
    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0);
    run_op(2'b11, 32'h1234, 32'h0, 32'h1234, 32'hFFFFFFFF, 1'b1);

    // cancel mid-RUN
    op = 2'b00; a = 32'd3; b = 32'd5; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("cancel_busy", busy, 0);
    chk("cancel_hi", hi, 32'h1234);
    chk("cancel_lo", lo, 32'hFFFFFFFF);
    repeat (40) tick();

    a = 32'hA5A5A5A5; mthi = 1'b1;
    tick();
    mthi = 1'b0;
    chk("mthi_hi", hi, 32'hA5A5A5A5);
    chk("mthi_lo_keep", lo, 32'hFFFFFFFF);
    a = 32'h5A5A5A5A; mtlo = 1'b1;
    tick();
    mtlo = 1'b0;
    chk("mtlo_lo", lo, 32'h5A5A5A5A);

    // start and mtlo together: start wins
    push(32'h0, 32'd6, 1'b0);
    op = 2'b01; a = 32'd2; b = 32'd3; start = 1'b1; mtlo = 1'b1;
    tick();
    start = 1'b0; mtlo = 1'b0;
    chk("start_wins_lo", lo, 32'h5A5A5A5A);
    chk("start_wins_busy", busy, 1);
    repeat (W + 1) tick();
    chk("start_wins_done", done, 1);
    tick();

    // independent ops flow; second mult waits for FIX to pass
    push(32'h0, 32'h4E20, 1'b0);
    op = 2'b00; a = 32'd100; b = 32'd200; start = 1'b1;
    tick();
    start = 1'b0;
    #1;
    chk("alu_nostall", stall, 0);
    chk("alu_busy", busy, 1);
    repeat (5) tick();
    push(32'h0, 32'd12, 1'b0);
    op = 2'b00; a = 32'hFFFFFFFD; b = 32'hFFFFFFFC; start = 1'b1;
    #1;
    chk("second_stall", stall, 1);
    k = 0;
    while (stall && k < 60) begin k++; tick(); end
    chk("second_stall_cycles", k, 28);
    chk("second_idle", busy, 0);
    tick();
    start = 1'b0;
    chk("second_busy", busy, 1);
    repeat (W) tick();
    chk("second_pre_done", done, 0);
    tick();
    chk("second_done", done, 1);
    tick();

    // async reset mid-RUN
    op = 2'b01; a = 32'd9; b = 32'd9; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    clrn = 1'b0;
    #1;
    chk("midrst_hi", hi, 0);
    chk("midrst_lo", lo, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    tick();
    clrn = 1'b1;
    repeat (40) tick();
    chk("queue_empty", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
